// File: rtl/reg_file_nr1w.sv
// Multi-read, single-write register file with byte enables, write-to-read bypass,
// optional hardwired zero entry and a reset-time clearing sequencer.
module reg_file_nr1w #(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_BYTES = DATA_WIDTH / 8,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0]              i_ren,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   i_raddr,
    input  logic [ADDR_WIDTH-1:0]          i_waddr,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    input  logic                           i_wen,
    input  logic [DATA_BYTES-1:0]          i_wbe,
    output logic [NUM_RD*DATA_WIDTH-1:0]   o_rdata,
    output logic                           o_ready
);

    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic {StInit, StRun} state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [ADDR_WIDTH:0]   w_cnt_d;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_run;
    logic                  w_wr_ok;
    logic [DATA_WIDTH-1:0] w_wr_merged;

    assign w_run   = (r_state == StRun);
    assign w_wr_ok = w_run && i_wen && !((ZERO_REG != 0) && (i_waddr == '0));
    assign o_ready = r_ready;

    // Post-write image of the addressed entry; shared by the write path and the bypass.
    always_comb begin
        w_wr_merged = r_mem[i_waddr];
        for (int unsigned b = 0; b < DATA_BYTES; b++) begin
            if (i_wbe[b]) begin
                w_wr_merged[8*b +: 8] = i_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            StInit: begin
                w_cnt_d = r_cnt + CNT_ONE;
                if (r_cnt == LAST_IDX) begin
                    w_state_d = StRun;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StInit;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_ready <= (w_state_d == StRun);
        end
    end

    // Storage is cleared by the init sequence rather than by reset.
    always_ff @(posedge clk) begin
        if (r_state == StInit) begin
            r_mem[r_cnt[ADDR_WIDTH-1:0]] <= '0;
        end else if (w_wr_ok) begin
            r_mem[i_waddr] <= w_wr_merged;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_raddr;
        logic [DATA_WIDTH-1:0] w_rd_val;
        logic [DATA_WIDTH-1:0] r_rdata;

        assign w_raddr = i_raddr[p*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            if ((ZERO_REG != 0) && (w_raddr == '0)) begin
                w_rd_val = '0;
            end else if ((BYPASS != 0) && i_wen && (w_raddr == i_waddr)) begin
                w_rd_val = w_wr_merged;
            end else begin
                w_rd_val = r_mem[w_raddr];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rdata <= '0;
            end else if (w_run && i_ren[p]) begin
                r_rdata <= w_rd_val;
            end
        end

        assign o_rdata[p*DATA_WIDTH +: DATA_WIDTH] = r_rdata;
    end

endmodule
